// File: rtl/seg7_sync_counter_display.sv
// Multi-digit synchronous BCD/hex up/down counter with a registered 7-segment
// decoder per digit. Byte layout per digit (bit 0..7): g f e d a b dp c.
module seg7_sync_counter_display #(
   parameter int DIGITS         = 3,
   parameter int BCD            = 1,
   parameter int BLANK_LZ       = 0,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                  input_clock,
   input  logic                  input_reset,
   input  logic                  input_enable,
   input  logic                  input_up,
   input  logic                  input_clear,
   input  logic                  input_load,
   input  logic [4*DIGITS-1:0]   input_load_value,
   input  logic [DIGITS-1:0]     input_dp_mask,
   output logic [4*DIGITS-1:0]   output_count,
   output logic                  output_wrap,
   output logic                  output_load_error,
   output logic [8*DIGITS-1:0]   output_segments
);

   localparam logic [3:0]          DIGIT_MAX = (BCD != 0) ? 4'd9 : 4'd15;
   localparam logic [8*DIGITS-1:0] SEG_OFF   = (SEG_ACTIVE_LOW != 0) ?
                                               {(8*DIGITS){1'b1}} : {(8*DIGITS){1'b0}};

   logic [4*DIGITS-1:0] r_count;
   logic                r_wrap;
   logic                r_load_error;
   logic [8*DIGITS-1:0] r_seg;

   logic [4*DIGITS-1:0] w_step_count;
   logic                w_carry;
   logic [3:0]          w_digit;
   logic [4*DIGITS-1:0] w_load_count;
   logic                w_load_bad;
   logic [8*DIGITS-1:0] w_seg_next;
   logic                w_upper_zero;
   logic [7:0]          w_byte;

   // Active-high glyph bits; dp (bit 6) is always clear here and added later.
   function automatic logic [7:0] glyph(input logic [3:0] v);
      case (v)
         4'h0:    glyph = 8'hBE;
         4'h1:    glyph = 8'hA0;
         4'h2:    glyph = 8'h3D;
         4'h3:    glyph = 8'hB9;
         4'h4:    glyph = 8'hA3;
         4'h5:    glyph = 8'h9B;
         4'h6:    glyph = 8'h9F;
         4'h7:    glyph = 8'hB0;
         4'h8:    glyph = 8'hBF;
         4'h9:    glyph = 8'hBB;
         4'hA:    glyph = 8'hB7;
         4'hB:    glyph = 8'h8F;
         4'hC:    glyph = 8'h1E;
         4'hD:    glyph = 8'hAD;
         4'hE:    glyph = 8'h1F;
         default: glyph = 8'h17;
      endcase
   endfunction

   // Carry/borrow ripples through all digits; a carry out of the top is a wrap.
   always_comb begin
      w_step_count = r_count;
      w_carry      = 1'b1;
      w_digit      = 4'd0;
      for (int d = 0; d < DIGITS; d++) begin
         w_digit = r_count[4*d +: 4];
         if (w_carry) begin
            if (input_up) begin
               if (w_digit == DIGIT_MAX) begin
                  w_step_count[4*d +: 4] = 4'd0;
               end else begin
                  w_step_count[4*d +: 4] = w_digit + 4'd1;
                  w_carry                = 1'b0;
               end
            end else begin
               if (w_digit == 4'd0) begin
                  w_step_count[4*d +: 4] = DIGIT_MAX;
               end else begin
                  w_step_count[4*d +: 4] = w_digit - 4'd1;
                  w_carry                = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      w_load_count = input_load_value;
      w_load_bad   = 1'b0;
      if (BCD != 0) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (input_load_value[4*d +: 4] > 4'd9) begin
               w_load_count[4*d +: 4] = 4'd0;
               w_load_bad             = 1'b1;
            end
         end
      end
   end

   // Walk from the top digit down so blanking stops at the first non-zero digit.
   always_comb begin
      w_seg_next   = '0;
      w_upper_zero = 1'b1;
      w_byte       = 8'h00;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         w_upper_zero = w_upper_zero && (r_count[4*d +: 4] == 4'd0);
         w_byte       = glyph(r_count[4*d +: 4]);
         if ((BLANK_LZ != 0) && (d != 0) && w_upper_zero) begin
            w_byte = 8'h00;
         end
         w_byte[6] = input_dp_mask[d];
         if (SEG_ACTIVE_LOW != 0) begin
            w_byte = ~w_byte;
         end
         w_seg_next[8*d +: 8] = w_byte;
      end
   end

   always_ff @(posedge input_clock) begin
      if (input_reset) begin
         r_count      <= '0;
         r_wrap       <= 1'b0;
         r_load_error <= 1'b0;
         r_seg        <= SEG_OFF;
      end else begin
         r_wrap       <= 1'b0;
         r_load_error <= 1'b0;
         r_seg        <= w_seg_next;
         if (input_clear) begin
            r_count <= '0;
         end else if (input_load) begin
            r_count      <= w_load_count;
            r_load_error <= w_load_bad;
         end else if (input_enable) begin
            r_count <= w_step_count;
            r_wrap  <= w_carry;
         end
      end
   end

   assign output_count      = r_count;
   assign output_wrap       = r_wrap;
   assign output_load_error = r_load_error;
   assign output_segments   = r_seg;

endmodule

// File: tb/tb_seg7_sync_counter_display.sv
// Scoreboard bench: four parameter variants share one stimulus stream; expected
// values are queued with a target cycle and checked by an independent monitor.
module tb_seg7_sync_counter_display;

   localparam int F_CNT = 0;
   localparam int F_WRP = 1;
   localparam int F_ERR = 2;
   localparam int F_SEG = 3;

   typedef struct {
      int          cyc;
      int          id;
      int          fld;
      logic [23:0] exp;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic        up;
   logic        clr;
   logic        ld;
   logic [11:0] ld_val;
   logic [2:0]  dp;

   logic [11:0] cnt  [4];
   logic        wrp  [4];
   logic        lerr [4];
   logic [23:0] seg  [4];

   int   cyc;
   int   errors;
   int   checks;
   exp_t sb[$];

   seg7_sync_counter_display #(.DIGITS(3), .BCD(1), .BLANK_LZ(0), .SEG_ACTIVE_LOW(0)) u0 (
      .input_clock(clk), .input_reset(rst), .input_enable(en), .input_up(up),
      .input_clear(clr), .input_load(ld), .input_load_value(ld_val), .input_dp_mask(dp),
      .output_count(cnt[0]), .output_wrap(wrp[0]), .output_load_error(lerr[0]),
      .output_segments(seg[0]));

   seg7_sync_counter_display #(.DIGITS(3), .BCD(0), .BLANK_LZ(0), .SEG_ACTIVE_LOW(0)) u1 (
      .input_clock(clk), .input_reset(rst), .input_enable(en), .input_up(up),
      .input_clear(clr), .input_load(ld), .input_load_value(ld_val), .input_dp_mask(dp),
      .output_count(cnt[1]), .output_wrap(wrp[1]), .output_load_error(lerr[1]),
      .output_segments(seg[1]));

   seg7_sync_counter_display #(.DIGITS(3), .BCD(1), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)) u2 (
      .input_clock(clk), .input_reset(rst), .input_enable(en), .input_up(up),
      .input_clear(clr), .input_load(ld), .input_load_value(ld_val), .input_dp_mask(dp),
      .output_count(cnt[2]), .output_wrap(wrp[2]), .output_load_error(lerr[2]),
      .output_segments(seg[2]));

   seg7_sync_counter_display #(.DIGITS(3), .BCD(1), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) u3 (
      .input_clock(clk), .input_reset(rst), .input_enable(en), .input_up(up),
      .input_clear(clr), .input_load(ld), .input_load_value(ld_val), .input_dp_mask(dp),
      .output_count(cnt[3]), .output_wrap(wrp[3]), .output_load_error(lerr[3]),
      .output_segments(seg[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] actual(input int id, input int fld);
      case (fld)
         F_CNT:   actual = {12'd0, cnt[id]};
         F_WRP:   actual = {23'd0, wrp[id]};
         F_ERR:   actual = {23'd0, lerr[id]};
         default: actual = seg[id];
      endcase
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'((v / 100) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      to_bcd = r;
   endfunction

   task automatic push_exp(input int off, input int id, input int fld,
                           input logic [23:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc + off;
      e.id   = id;
      e.fld  = fld;
      e.exp  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Monitor: every output is registered, so the falling edge is a stable sample point.
   always @(negedge clk) begin
      int          i;
      exp_t        e;
      logic [23:0] act;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc <= cyc) begin
            e = sb[i];
            sb.delete(i);
            checks++;
            act = actual(e.id, e.fld);
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL %s dut%0d: check for cycle %0d missed at cycle %0d", e.name, e.id, e.cyc, cyc);
            end else if (act !== e.exp) begin
               errors++;
               $display("FAIL %s dut%0d cyc %0d: got %h expected %h", e.name, e.id, cyc, act, e.exp);
            end
         end else begin
            i++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = 12'h000; dp = 3'b000;

      // reset values
      @(negedge clk);
      @(negedge clk);
      push_exp(1, 0, F_CNT, 24'h0, "rst_count");
      push_exp(1, 0, F_WRP, 24'h0, "rst_wrap");
      push_exp(1, 0, F_ERR, 24'h0, "rst_lerr");
      push_exp(1, 0, F_SEG, 24'h000000, "rst_seg");
      push_exp(1, 3, F_SEG, 24'hFFFFFF, "rst_seg_al");
      @(negedge clk);
      rst = 1'b0;
      push_exp(1, 0, F_CNT, 24'h0, "idle_count");
      push_exp(1, 0, F_SEG, 24'hBEBEBE, "idle_seg");
      push_exp(1, 2, F_SEG, 24'h0000BE, "idle_seg_blank");
      push_exp(1, 3, F_SEG, 24'hFFFF41, "idle_seg_blank_al");
      @(negedge clk);

      // 1000 up edges
      en = 1'b1;
      up = 1'b1;
      for (int k = 1; k <= 1000; k++) begin
         push_exp(1, 0, F_CNT, {12'd0, to_bcd(k % 1000)}, "up_count_bcd");
         push_exp(1, 0, F_WRP, (k == 1000) ? 24'h1 : 24'h0, "up_wrap_bcd");
         push_exp(1, 1, F_CNT, 24'(k), "up_count_hex");
         push_exp(1, 1, F_WRP, 24'h0, "up_wrap_hex");
         if (k == 19) begin
            push_exp(2, 0, F_SEG, 24'hBEA0BB, "seg_019");
            push_exp(2, 2, F_SEG, 24'h00A0BB, "seg_019_blank");
         end
         @(negedge clk);
      end
      en = 1'b0;

      // load zero then count down across the wrap, then reverse direction
      ld = 1'b1; ld_val = 12'h000;
      push_exp(1, 0, F_CNT, 24'h000, "load0");
      push_exp(1, 0, F_WRP, 24'h0, "load0_wrap");
      push_exp(1, 0, F_ERR, 24'h0, "load0_lerr");
      @(negedge clk);
      ld = 1'b0; en = 1'b1; up = 1'b0;
      push_exp(1, 0, F_CNT, 24'h999, "down_wrap_count");
      push_exp(1, 0, F_WRP, 24'h1, "down_wrap");
      push_exp(1, 1, F_CNT, 24'hFFF, "down_wrap_count_hex");
      push_exp(1, 1, F_WRP, 24'h1, "down_wrap_hex");
      @(negedge clk);
      push_exp(1, 0, F_CNT, 24'h998, "down_count");
      push_exp(1, 0, F_WRP, 24'h0, "down_nowrap");
      push_exp(1, 1, F_CNT, 24'hFFE, "down_count_hex");
      @(negedge clk);
      up = 1'b1;
      push_exp(1, 0, F_CNT, 24'h999, "reverse_count");
      push_exp(1, 0, F_WRP, 24'h0, "reverse_nowrap");
      push_exp(1, 1, F_CNT, 24'hFFF, "reverse_count_hex");
      @(negedge clk);
      push_exp(1, 0, F_CNT, 24'h000, "up_wrap2_count");
      push_exp(1, 0, F_WRP, 24'h1, "up_wrap2");
      push_exp(1, 1, F_CNT, 24'h000, "up_wrap2_count_hex");
      push_exp(1, 1, F_WRP, 24'h1, "up_wrap2_hex");
      @(negedge clk);
      en = 1'b0;

      // invalid BCD nibble on load
      ld = 1'b1; ld_val = 12'h1A5;
      push_exp(1, 0, F_CNT, 24'h105, "load_bad_count");
      push_exp(1, 0, F_ERR, 24'h1, "load_bad_lerr");
      push_exp(1, 1, F_CNT, 24'h1A5, "load_hex_count");
      push_exp(1, 1, F_ERR, 24'h0, "load_hex_lerr");
      @(negedge clk);
      ld = 1'b0;
      push_exp(1, 0, F_ERR, 24'h0, "lerr_one_cycle");
      push_exp(1, 0, F_CNT, 24'h105, "hold_count");
      push_exp(1, 0, F_SEG, 24'hA0BE9B, "seg_105");
      push_exp(1, 1, F_SEG, 24'hA0B79B, "seg_1A5_hex");
      @(negedge clk);

      // blanking, dp and polarity
      ld = 1'b1; ld_val = 12'h007; dp = 3'b100;
      push_exp(1, 0, F_CNT, 24'h007, "load_007");
      @(negedge clk);
      ld = 1'b0;
      push_exp(1, 2, F_SEG, 24'h4000B0, "seg_007_blank");
      push_exp(1, 3, F_SEG, 24'hBFFF4F, "seg_007_blank_al");
      push_exp(1, 0, F_SEG, 24'hFEBEB0, "seg_007_dp");
      @(negedge clk);
      ld = 1'b1; ld_val = 12'h100; dp = 3'b000;
      @(negedge clk);
      ld = 1'b0;
      push_exp(1, 2, F_SEG, 24'hA0BEBE, "seg_100_blank");
      push_exp(1, 3, F_SEG, 24'h5F4141, "seg_100_blank_al");
      @(negedge clk);
      ld = 1'b1; ld_val = 12'h070;
      @(negedge clk);
      ld = 1'b0;
      push_exp(1, 2, F_SEG, 24'h00B0BE, "seg_070_blank");
      @(negedge clk);

      // priority: clear over load over enable
      ld = 1'b1; ld_val = 12'h123;
      push_exp(1, 0, F_CNT, 24'h123, "load_123");
      @(negedge clk);
      clr = 1'b1; ld = 1'b1; en = 1'b1; up = 1'b1; ld_val = 12'h5A5;
      push_exp(1, 0, F_CNT, 24'h000, "clear_wins");
      push_exp(1, 0, F_ERR, 24'h0, "clear_wins_lerr");
      push_exp(1, 0, F_WRP, 24'h0, "clear_wins_wrap");
      @(negedge clk);
      clr = 1'b0; en = 1'b0;
      ld = 1'b1; ld_val = 12'h999;
      push_exp(1, 0, F_CNT, 24'h999, "load_999");
      @(negedge clk);

      // reset beats load and a would-be wrap
      rst = 1'b1; ld = 1'b1; en = 1'b1; up = 1'b1; ld_val = 12'h789;
      push_exp(1, 0, F_CNT, 24'h000, "reset_wins_count");
      push_exp(1, 0, F_WRP, 24'h0, "reset_wins_wrap");
      push_exp(1, 0, F_SEG, 24'h000000, "reset_wins_seg");
      push_exp(1, 3, F_SEG, 24'hFFFFFF, "reset_wins_seg_al");
      push_exp(1, 2, F_CNT, 24'h000, "reset_wins_count_b");
      @(negedge clk);
      rst = 1'b0; ld = 1'b0; en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
